ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 rdy  in  1  global enable; 0 freezes every register.
REQ-005 jump_i  in  1  redirect request from commit/branch unit; same signal drives the downstream queue's flush.
REQ-006 jump_addr_i  in  32  redirect target PC.
REQ-007 iq_full_i  in  1  downstream instruction-queue full flag (registered, lookahead).
REQ-008 iq_we_o  out  1  one-cycle push strobe to the instruction queue.
REQ-009 iq_inst_o  out  32  fetched instruction word.
REQ-010 iq_pc_o  out  32  PC of iq_inst_o.
REQ-011 mem_req_o  out  1  fetch request to the memory controller, level, held until done.
REQ-012 mem_addr_o  out  32  word-aligned fetch address.
REQ-013 mem_done_i  in  1  one-cycle completion pulse from the memory controller.
REQ-014 mem_data_i  in  32  instruction word, valid only while mem_done_i=1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (no request outstanding), BUSY (request outstanding, result wanted) and DROP (request outstanding, result to be discarded).
REQ-016 IDLE, rdy=1, jump_i=0, iq_full_i=0: set mem_req_o=1 and mem_addr_o=pc on the next edge; go to BUSY.
REQ-017 IDLE, iq_full_i=1: no request; stay in IDLE; pc unchanged.
REQ-018 BUSY: mem_req_o and mem_addr_o SHALL stay stable until mem_done_i=1; the request is never withdrawn early.
REQ-019 BUSY, mem_done_i=1, jump_i=0: on that edge, set iq_we_o=1, iq_inst_o=mem_data_i, iq_pc_o=pc, pc=pc+4 (32-bit wrap), mem_req_o=0; go to IDLE.
REQ-020 iq_we_o SHALL be high for exactly one rdy=1 cycle per accepted fetch; done-to-push latency is 1 cycle; fetch-to-fetch throughput is at most one instruction every 3 cycles.
REQ-021 jump_i=1 in IDLE: pc=jump_addr_i with bits [1:0] forced to 0; stay in IDLE; no request in that cycle.
REQ-022 jump_i=1 in BUSY, mem_done_i=0: pc=jump target; go to DROP; mem_req_o stays 1 with the old address.
REQ-023 jump_i=1 in BUSY, mem_done_i=1 in the same cycle: discard the data; iq_we_o=0; pc=jump target; mem_req_o=0; go to IDLE.
REQ-024 DROP, mem_done_i=1: discard the data; mem_req_o=0; go to IDLE. A further jump_i in DROP only updates pc.
REQ-025 iq_we_o SHALL never be 1 in the cycle after a cycle with jump_i=1.
REQ-026 rdy=0: hold all state and outputs; mem_done_i and jump_i are ignored. The memory controller and queue are gated by the same rdy.
REQ-027 At most one request SHALL be outstanding; the queue's lookahead full flag is trusted without extra margin.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, pc=RESET_PC, mem_req_o=0, mem_addr_o=0, iq_we_o=0, iq_inst_o=0, iq_pc_o=0, regardless of clk or rdy.
REQ-029 Reset asserted mid-request drops the outstanding request; the memory controller shares the same reset.

Structure
REQ-030 A shared package SHALL hold the state encoding (2 bits: IDLE=0, BUSY=1, DROP=2), RESET_PC default and the instruction/address width constant 32.
REQ-031 The block SHALL be a single module with no sub-module; the PC incrementer and redirect mux are inline.

Verification
REQ-032 Reset release, memory returns 32'h00000013 after 2 cycles -> mem_addr_o=0, iq_we_o pulse with iq_pc_o=0 and iq_inst_o=32'h00000013; next mem_addr_o=4.
REQ-033 iq_full_i=1 for 5 cycles in IDLE -> mem_req_o stays 0; after full drops, request at the unchanged pc.
REQ-034 jump_i with jump_addr_i=32'h104 in BUSY, done 3 cycles later -> no iq_we_o; next request at addr 32'h104.
REQ-035 jump_i coincident with mem_done_i, target 32'h200 -> no push; next mem_addr_o=32'h200.
REQ-036 pc=32'hFFFFFFFC fetch completes -> iq_pc_o=32'hFFFFFFFC; next mem_addr_o=0.
REQ-037 rst pulled low between clock edges while BUSY -> outputs reset at once; after release, first fetch at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// datapath width and the default reset PC.
package ifetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch unit: keeps one memory request in flight at most, pushes
// returned words into the instruction queue and squashes fetches on redirect.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            iq_full_i,
    output logic            iq_we_o,
    output logic [XLEN-1:0] iq_inst_o,
    output logic [XLEN-1:0] iq_pc_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_done_i,
    input  logic [XLEN-1:0] mem_data_i
);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            mem_req_q;
    logic [XLEN-1:0] mem_addr_q;
    logic            iq_we_q;
    logic [XLEN-1:0] iq_inst_q;
    logic [XLEN-1:0] iq_pc_q;

    logic [XLEN-1:0] jump_pc_d;
    logic [XLEN-1:0] pc_plus4_d;

    assign jump_pc_d  = alignPc(jump_addr_i);
    assign pc_plus4_d = pc_q + XLEN'(4);

    // A redirect always wins over returning data; an in-flight request is
    // never withdrawn, only marked for discard via DROP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            iq_we_q    <= 1'b0;
            iq_inst_q  <= '0;
            iq_pc_q    <= '0;
        end else if (rdy) begin
            iq_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (jump_i) begin
                        pc_q <= jump_pc_d;
                    end else if (!iq_full_i) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= alignPc(pc_q);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (jump_i) begin
                        pc_q <= jump_pc_d;
                        if (mem_done_i) begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= DROP;
                        end
                    end else if (mem_done_i) begin
                        iq_we_q   <= 1'b1;
                        iq_inst_q <= mem_data_i;
                        iq_pc_q   <= pc_q;
                        pc_q      <= pc_plus4_d;
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DROP: begin
                    if (jump_i) begin
                        pc_q <= jump_pc_d;
                    end
                    if (mem_done_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign iq_we_o    = iq_we_q;
    assign iq_inst_o  = iq_inst_q;
    assign iq_pc_o    = iq_pc_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a memory responder answers requests, the
// stimulus queues expected requests/pushes and a monitor checks them.
module tb_ifetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } push_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        iq_full_i;
    logic        iq_we_o;
    logic [31:0] iq_inst_o;
    logic [31:0] iq_pc_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_done_i;
    logic [31:0] mem_data_i;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] expAddr[$];
    push_t       expPush[$];
    int          memLat;
    logic        respPending;
    logic        jumpAtEdge;

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .iq_full_i   (iq_full_i),
        .iq_we_o     (iq_we_o),
        .iq_inst_o   (iq_inst_o),
        .iq_pc_o     (iq_pc_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_done_i  (mem_done_i),
        .mem_data_i  (mem_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0], 16'h0093};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".mem_req"},  {31'b0, mem_req_o}, 32'h0);
        checkOutput({tag, ".mem_addr"}, mem_addr_o, 32'h0);
        checkOutput({tag, ".iq_we"},    {31'b0, iq_we_o}, 32'h0);
        checkOutput({tag, ".iq_inst"},  iq_inst_o, 32'h0);
        checkOutput({tag, ".iq_pc"},    iq_pc_o, 32'h0);
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(expAddr.size() == 0 && expPush.size() == 0 && !mem_req_o && !respPending)
                   && n < maxCycles);
        if (!(expAddr.size() == 0 && expPush.size() == 0 && !mem_req_o && !respPending)) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drainTimeout: %0d requests and %0d pushes still pending after %0d cycles",
                     expAddr.size(), expPush.size(), maxCycles);
        end
    endtask

    // Let exactly one fetch through from IDLE and wait for it to complete.
    task automatic applyStimulus(input logic [31:0] addr);
        push_t p;
        p.pc   = addr;
        p.inst = memWord(addr);
        expAddr.push_back(addr);
        expPush.push_back(p);
        iq_full_i = 1'b0;
        @(negedge clk);
        iq_full_i = 1'b1;
        waitDrain(40);
    endtask

    // Memory controller model, frozen by rdy and cleared by reset.
    initial begin
        int          cnt;
        logic [31:0] reqAddr;
        mem_done_i  = 1'b0;
        mem_data_i  = 32'h0;
        respPending = 1'b0;
        cnt         = 0;
        reqAddr     = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                respPending = 1'b0;
                mem_done_i  = 1'b0;
            end else if (rdy) begin
                mem_done_i = 1'b0;
                if (respPending) begin
                    if (cnt > 1) begin
                        cnt--;
                    end else begin
                        mem_done_i  = 1'b1;
                        mem_data_i  = memWord(reqAddr);
                        respPending = 1'b0;
                    end
                end else if (mem_req_o) begin
                    respPending = 1'b1;
                    reqAddr     = mem_addr_o;
                    cnt         = memLat;
                end
            end
        end
    end

    always @(posedge clk) jumpAtEdge = jump_i;

    // Monitor: match each new request and each push against the scoreboard.
    initial begin
        logic  prevReq;
        push_t p;
        prevReq = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevReq = 1'b0;
            end else begin
                if (mem_req_o && !prevReq) begin
                    if (expAddr.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpectedReq: got request at %h, expected none", mem_addr_o);
                    end else begin
                        checkOutput("reqAddr", mem_addr_o, expAddr.pop_front());
                    end
                end
                if (iq_we_o && rdy) begin
                    checkOutput("noPushAfterJump", {31'b0, jumpAtEdge}, 32'h0);
                    if (expPush.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpectedPush: got push pc %h inst %h, expected none",
                                 iq_pc_o, iq_inst_o);
                    end else begin
                        p = expPush.pop_front();
                        checkOutput("pushPc", iq_pc_o, p.pc);
                        checkOutput("pushInst", iq_inst_o, p.inst);
                    end
                end
                prevReq = mem_req_o;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        push_t p;
        rst         = 1'b0;
        rdy         = 1'b1;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;
        iq_full_i   = 1'b1;
        memLat      = 2;

        repeat (2) @(negedge clk);
        checkReset("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] first fetches after reset");
        applyStimulus(32'h0);
        applyStimulus(32'h4);

        $display("[TB] queue full holds off fetching");
        repeat (5) begin
            @(negedge clk);
            checkOutput("fullNoReq", {31'b0, mem_req_o}, 32'h0);
        end
        applyStimulus(32'h8);

        $display("[TB] rdy low freezes an outstanding request");
        p.pc   = 32'hC;
        p.inst = memWord(32'hC);
        expAddr.push_back(32'hC);
        expPush.push_back(p);
        iq_full_i = 1'b0;
        @(negedge clk);
        iq_full_i = 1'b1;
        rdy       = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("stallReq", {31'b0, mem_req_o}, 32'h1);
            checkOutput("stallAddr", mem_addr_o, 32'hC);
        end
        rdy = 1'b1;
        waitDrain(40);

        $display("[TB] redirect while busy");
        memLat = 3;
        expAddr.push_back(32'h10);
        iq_full_i = 1'b0;
        @(negedge clk);
        iq_full_i   = 1'b1;
        jump_i      = 1'b1;
        jump_addr_i = 32'h104;
        @(negedge clk);
        jump_i = 1'b0;
        checkOutput("dropHoldsReq", {31'b0, mem_req_o}, 32'h1);
        checkOutput("dropHoldsAddr", mem_addr_o, 32'h10);
        waitDrain(40);
        memLat = 2;
        applyStimulus(32'h104);

        $display("[TB] redirect coincident with completion");
        memLat = 1;
        expAddr.push_back(32'h108);
        iq_full_i = 1'b0;
        @(negedge clk);
        iq_full_i = 1'b1;
        @(negedge clk);
        jump_i      = 1'b1;
        jump_addr_i = 32'h200;
        @(negedge clk);
        jump_i = 1'b0;
        checkOutput("coincidentNoPush", {31'b0, iq_we_o}, 32'h0);
        checkOutput("coincidentReqDrop", {31'b0, mem_req_o}, 32'h0);
        waitDrain(40);
        memLat = 2;
        applyStimulus(32'h200);

        $display("[TB] redirect in idle aligns target");
        p.pc   = 32'h300;
        p.inst = memWord(32'h300);
        expAddr.push_back(32'h300);
        expPush.push_back(p);
        jump_i      = 1'b1;
        jump_addr_i = 32'h303;
        iq_full_i   = 1'b0;
        @(negedge clk);
        jump_i = 1'b0;
        checkOutput("idleJumpNoReq", {31'b0, mem_req_o}, 32'h0);
        @(negedge clk);
        iq_full_i = 1'b1;
        waitDrain(40);

        $display("[TB] pc wraps at top of address space");
        jump_i      = 1'b1;
        jump_addr_i = 32'hFFFF_FFFF;
        @(negedge clk);
        jump_i = 1'b0;
        applyStimulus(32'hFFFF_FFFC);
        applyStimulus(32'h0);

        $display("[TB] asynchronous reset during a request");
        memLat = 3;
        expAddr.push_back(32'h4);
        iq_full_i = 1'b0;
        @(negedge clk);
        iq_full_i = 1'b1;
        #3 rst = 1'b0;
        #1 checkReset("asyncReset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        memLat = 2;
        applyStimulus(32'h0);

        repeat (3) @(negedge clk);
        checkOutput("leftoverReqs", expAddr.size(), 32'h0);
        checkOutput("leftoverPushes", expPush.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
